// File: rtl/data_mem_ws.sv
// Word-organised data memory with a valid/ready request port, programmable wait
// states, misalignment/illegal-size error reporting and a one-cycle response pulse.
module data_mem_ws #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rdata,
  output logic        busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int AW = ADDR_WIDTH + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  function automatic logic req_is_err(input logic wr, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic err;
    err = 1'b1;
    case (f3)
      3'b000:  err = 1'b0;
      3'b001:  err = a[0];
      3'b010:  err = (a != 2'b00);
      3'b100:  err = wr;
      3'b101:  err = wr | a[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [2:0]        func3_q, func3_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;

  logic [31:0]           mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [31:0]           rd_word_s;
  logic                  mem_we_s;
  logic [3:0]            wr_be_s;
  logic [31:0]           wr_data_s;
  logic                  unused_addr_s;

  // Bits above the array size are ignored, which makes the memory alias.
  assign unused_addr_s = ^addr[31:AW];
  assign word_idx_s    = addr_q[AW-1:2];
  assign rd_word_s     = mem_q[word_idx_s];

  // Store byte enables and lane-replicated write data.
  always_comb begin
    wr_be_s   = 4'b0000;
    wr_data_s = 32'd0;
    case (func3_q)
      3'b000: begin
        wr_be_s   = 4'b0001 << addr_q[1:0];
        wr_data_s = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        wr_be_s   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data_s = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        wr_be_s   = 4'b1111;
        wr_data_s = wdata_q;
      end
      default: begin
        wr_be_s   = 4'b0000;
        wr_data_s = 32'd0;
      end
    endcase
  end

  // Request FSM: next state, latched request and registered response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rdata_d     = rdata_q;
    mem_we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          func3_d = func3;
          addr_d  = addr[AW-1:0];
          wdata_d = wdata;
          if (req_is_err(req_write, func3, addr[1:0])) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rdata_d     = 32'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          mem_we_s    = write_q;
          rdata_d     = write_q ? 32'd0 : load_ext(func3_q, addr_q[1:0], rd_word_s);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      func3_q     <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= 32'd0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      func3_q     <= func3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
    end
  end

  // Array is not reset; a store only lands on its access edge.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_s[b]) begin
          mem_q[word_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = ready_q;
  assign busy      = ~ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rdata     = rdata_q;
endmodule

// File: tb/tb_data_mem_ws.sv
// Bench for data_mem_ws: byte-addressed reference model checked every cycle,
// plus directed transactions with hand-computed results and latency checks.
module tb_data_mem_ws;
  localparam int AWID = 8;
  localparam int WS   = 2;
  localparam int NB   = 4 * (2 ** AWID);

  logic        clk, rst;
  logic        req_valid, req_valid0, req_write;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rdata;
  logic        req_ready0, rsp_valid0, rsp_err0, busy0;
  logic [31:0] rdata0;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_ws #(.ADDR_WIDTH(AWID), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .func3(func3), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rdata(rdata), .busy(busy));

  data_mem_ws #(.ADDR_WIDTH(AWID), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .func3(func3), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid0), .rsp_err(rsp_err0), .rdata(rdata0), .busy(busy0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // ---------------- reference model (byte array, edge-count timing) ----------
  logic [7:0]  mb [NB];
  int          n_edge = 0, r_edge = 0, p_edge = 0;
  bit          pend = 0, was_ready = 0;
  logic        p_wr = 0;
  logic [2:0]  p_f3 = 0;
  logic [31:0] p_addr = 0, p_wdata = 0;
  logic        exp_valid = 0, exp_err = 0;
  logic [31:0] exp_rdata = 0;

  initial for (int i = 0; i < NB; i++) mb[i] = 8'd0;

  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_err(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = wr ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int sz, base;
    logic [31:0] v;
    sz = acc_size(f3);
    base = int'(a % NB);
    v = 32'd0;
    for (int k = 0; k < sz; k++) v = v | (32'(mb[(base + k) % NB]) << (8 * k));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_edge = 0; r_edge = 0; pend = 0;
      exp_valid = 0; exp_err = 0; exp_rdata = 32'd0;
    end else begin
      was_ready = (n_edge >= r_edge);
      n_edge++;
      exp_valid = 0;
      if (pend && n_edge == p_edge) begin
        pend = 0; exp_valid = 1; exp_err = 0;
        if (p_wr) begin
          for (int k = 0; k < acc_size(p_f3); k++)
            mb[(int'(p_addr % NB) + k) % NB] = p_wdata[8*k +: 8];
          exp_rdata = 32'd0;
        end else begin
          exp_rdata = m_load(p_f3, p_addr);
        end
      end
      if (was_ready && req_valid) begin
        if (m_err(req_write, func3, addr)) begin
          exp_valid = 1; exp_err = 1; exp_rdata = 32'd0;
          r_edge = n_edge + 1;
        end else begin
          pend = 1; p_edge = n_edge + WS + 1; r_edge = n_edge + WS + 2;
          p_wr = req_write; p_f3 = func3; p_addr = addr; p_wdata = wdata;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk1("cyc rsp_valid", rsp_valid, exp_valid);
      chk1("cyc req_ready", req_ready, n_edge >= r_edge);
      chk1("cyc busy", busy, n_edge < r_edge);
      chk1("cyc rsp_err", rsp_err, exp_err);
      chk32("cyc rdata", rdata, exp_rdata);
    end
  end

  // ---------------- directed stimulus ----------------------------------------
  task automatic timeout_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout, got no event expected one within 40 cycles", nm);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) timeout_fail("wait_ready");
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_e, input string nm);
    int k;
    wait_ready();
    req_write = wr; func3 = f3; addr = a; wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) timeout_fail(nm);
    else begin
      chk32({nm, " rdata"}, rdata, exp_rd);
      chk1({nm, " rsp_err"}, rsp_err, exp_e);
    end
  endtask

  int pulses;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0; req_write = 1'b0;
    func3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset rsp_valid", rsp_valid, 1'b0);
    chk1("reset req_ready", req_ready, 1'b1);
    chk1("reset busy", busy, 1'b0);
    chk1("reset rsp_err", rsp_err, 1'b0);
    chk32("reset rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_req(1'b1, 3'b010, 32'h0, 32'h0000_06F4, 32'h0, 1'b0, "sw @0");
    do_req(1'b0, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFF4, 1'b0, "lb @0");
    do_req(1'b0, 3'b100, 32'h0, 32'h0, 32'h0000_00F4, 1'b0, "lbu @0");
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'h0000_06F4, 1'b0, "lw @0");
    do_req(1'b1, 3'b010, 32'h4, 32'h0004_E634, 32'h0, 1'b0, "sw @4");
    do_req(1'b0, 3'b001, 32'h4, 32'h0, 32'hFFFF_E634, 1'b0, "lh @4");
    do_req(1'b0, 3'b101, 32'h4, 32'h0, 32'h0000_E634, 1'b0, "lhu @4");
    do_req(1'b0, 3'b101, 32'h6, 32'h0, 32'h0000_0004, 1'b0, "lhu @6");
    do_req(1'b1, 3'b000, 32'h1, 32'h1234_56AB, 32'h0, 1'b0, "sb @1");
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'h0000_ABF4, 1'b0, "lw after sb");
    do_req(1'b1, 3'b001, 32'h2, 32'h0000_BEEF, 32'h0, 1'b0, "sh @2");
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'hBEEF_ABF4, 1'b0, "lw after sh");

    // latency with two wait states: response in interval 3, ready back in 4
    wait_ready();
    req_write = 1'b0; func3 = 3'b010; addr = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      chk1($sformatf("ws2 rsp_valid k=%0d", k), rsp_valid, k == 3);
      chk1($sformatf("ws2 req_ready k=%0d", k), req_ready, k == 4);
    end

    // latency with zero wait states
    @(negedge clk);
    req_write = 1'b0; func3 = 3'b010; addr = 32'h0; req_valid0 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) req_valid0 = 1'b0;
      chk1($sformatf("ws0 rsp_valid k=%0d", k), rsp_valid0, k == 1);
      chk1($sformatf("ws0 req_ready k=%0d", k), req_ready0, k == 2);
    end

    // error requests: response on the cycle right after accept
    wait_ready();
    req_write = 1'b0; func3 = 3'b010; addr = 32'h2; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk1("lw @2 rsp_valid", rsp_valid, 1'b1);
    chk1("lw @2 rsp_err", rsp_err, 1'b1);
    chk32("lw @2 rdata", rdata, 32'd0);
    do_req(1'b1, 3'b001, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, "sh @1");
    do_req(1'b1, 3'b100, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, "store f3=100");
    do_req(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, "load f3=011");
    do_req(1'b0, 3'b101, 32'h3, 32'h0, 32'h0, 1'b1, "lhu @3");
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'hBEEF_ABF4, 1'b0, "lw after errors");

    // request held valid through responses: back-to-back accepts
    wait_ready();
    req_write = 1'b0; func3 = 3'b010; addr = 32'h4; req_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
    end
    req_valid = 1'b0;
    chk32("held valid pulses", 32'(pulses), 32'd2);

    // reset mid-store drops the store
    do_req(1'b1, 3'b010, 32'h8, 32'h0, 32'h0, 1'b0, "sw 0 @8");
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'hBEEF_ABF4, 1'b0, "lw @0 pre-reset");
    wait_ready();
    req_write = 1'b1; func3 = 3'b010; addr = 32'h8; wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk1("midrst rsp_valid", rsp_valid, 1'b0);
    chk1("midrst req_ready", req_ready, 1'b1);
    chk1("midrst busy", busy, 1'b0);
    chk1("midrst rsp_err", rsp_err, 1'b0);
    chk32("midrst rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_req(1'b0, 3'b010, 32'h8, 32'h0, 32'h0000_0000, 1'b0, "lw @8 after reset");

    // aliasing above the array size
    do_req(1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b0, "sw @400");
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, "lw @0 alias");
    do_req(1'b0, 3'b000, 32'h401, 32'h0, 32'hFFFF_FFF0, 1'b0, "lb @401");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
